// File: rtl/sum_acum_pipe.sv
// Accumulates N_SAMPLES valid sums from the adder pipeline into an ACC_W-bit total
// and hands the total downstream through a valid/ready handshake.
module sum_acum_pipe #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned ACC_W     = 8,
    parameter int unsigned N_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              sum_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    output logic              busy,
    output logic              overflow,
    output logic [3:0]        count,
    output logic              drop
);

    typedef enum logic [1:0] {StIdle, StAcum, StHold} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               drop_q, drop_d;
    logic               out_valid_q, busy_q;
    logic [ACC_W:0]     sum_ext;

    // Extra top bit captures the carry out of the accumulator.
    assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(sum_in);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        drop_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                drop_d = sum_valid;
                if (start) begin
                    state_d = StAcum;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            StAcum: begin
                // Restart beats a coincident sample, which is discarded silently.
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (sum_valid) begin
                    acc_d   = sum_ext[ACC_W-1:0];
                    ovf_d   = ovf_q | sum_ext[ACC_W];
                    count_d = count_q + 4'd1;
                    if (count_q == 4'(N_SAMPLES - 1)) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                drop_d = sum_valid;
                if (out_ready) begin
                    if (start) begin
                        state_d = StAcum;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            out_valid_q <= (state_d == StHold);
            busy_q      <= (state_d == StAcum);
        end
    end

    assign acc_out   = acc_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;
    assign count     = count_q;
    assign drop      = drop_q;

endmodule
